// File: rtl/neuron_mac_accumulator.sv
// -----------------------------------------------------------------------------
// neuron_mac_accumulator
//   Sums N_INPUTS activation x weight products (Q4.13 x Q4.13 -> Q8.26) into
//   a 48-bit signed accumulator, adds a bias, and emits the result as 18-bit
//   sign-magnitude Q4.13 for the sigmoid stage. Out-of-range magnitudes are
//   saturated and flagged with overflow.
//
//   Build option: define NEURON_MAC_ROUND_EN to round half-up when
//   dropping the 13 low fraction bits. Without it the result is truncated
//   toward minus infinity.
// -----------------------------------------------------------------------------
module neuron_mac_accumulator #(
    parameter int N_INPUTS = 784,
    parameter int CNT_W    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_act,
    input  logic [17:0] in_weight,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_data,
    output logic        overflow,
    output logic        busy
);

    localparam int              ACC_W    = 48;
    localparam int              PROD_W   = 36;
    localparam int              FRAC_W   = 13;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam logic [ACC_W-1:0] MAG_MAX  = ACC_W'(17'h1FFFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_FIN,
        S_HOLD
    } state_t;

    // Registered state
    state_t                    state_q,     state_d;
    logic                      in_ready_q,  in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic [17:0]               out_data_q,  out_data_d;
    logic                      overflow_q,  overflow_d;
    logic                      busy_q,      busy_d;
    logic [17:0]               bias_q,      bias_d;
    logic [ACC_W-1:0]          acc_q,       acc_d;
    logic [CNT_W-1:0]          cnt_q,       cnt_d;
    logic signed [PROD_W-1:0]  prod_q,      prod_d;
    logic                      prod_vld_q,  prod_vld_d;

    // Finalisation datapath (only consumed in FIN)
    logic signed [ACC_W-1:0]   sum_s;
    logic signed [ACC_W-1:0]   rnd_s;
    logic signed [ACC_W-1:0]   shr_s;
    logic [ACC_W-1:0]          mag;
    logic                      res_neg;
    logic [17:0]               fin_data;
    logic                      fin_ovf;
    logic signed [PROD_W-1:0]  beat_prod;
    logic                      beat_acc;

    // Signed 18x18 product, operands sign-extended so the 36-bit result is exact
    always_comb begin
        beat_prod = $signed({{18{in_act[17]}}, in_act}) *
                    $signed({{18{in_weight[17]}}, in_weight});
    end

    assign beat_acc = in_valid && in_ready_q;

    // Bias alignment, optional rounding, shift back to Q4.13 and sign-magnitude conversion
    always_comb begin
        sum_s = $signed(acc_q) +
                ($signed({{(ACC_W-18){bias_q[17]}}, bias_q}) <<< FRAC_W);
`ifdef NEURON_MAC_ROUND_EN
        rnd_s = sum_s + $signed(ACC_W'(1) << (FRAC_W - 1));
`else
        rnd_s = sum_s;
`endif
        shr_s   = rnd_s >>> FRAC_W;
        res_neg = shr_s[ACC_W-1];
        // A negative shr_s always has magnitude >= 1, so zero never gets sign 1.
        mag     = res_neg ? ACC_W'(-shr_s) : ACC_W'(shr_s);
        if (mag > MAG_MAX) begin
            fin_data = {res_neg, 17'h1FFFF};
            fin_ovf  = 1'b1;
        end else begin
            fin_data = {res_neg, mag[16:0]};
            fin_ovf  = 1'b0;
        end
    end

    // Next-state logic for the control FSM, product stage and accumulator
    always_comb begin
        // NOTE: every _d gets a default up front so no path through the case leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;
        bias_d      = bias_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        prod_vld_d  = 1'b0;

        // Product stage drains into the accumulator one cycle after capture
        if (prod_vld_q) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    bias_d     = bias;
                    acc_d      = '0;
                    cnt_d      = '0;
                    prod_vld_d = 1'b0;
                    in_ready_d = 1'b1;
                    state_d    = S_ACC;
                end
            end
            S_ACC: begin
                if (beat_acc) begin
                    prod_d     = beat_prod;
                    prod_vld_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        in_ready_d = 1'b0;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                out_data_d  = fin_data;
                overflow_d  = fin_ovf;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State register with asynchronous reset; every output comes straight from a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            bias_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac_accumulator
//   Directed bench: a table of 4-beat neurons on an N_INPUTS=4 instance plus
//   hand-written sequences for HOLD backpressure, mid-run reset and an
//   N_INPUTS=1 instance exercising the rounding option (NEURON_MAC_ROUND_EN).
// -----------------------------------------------------------------------------
module tb_neuron_mac_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, in_valid, out_ready;
    logic [17:0] bias, in_act, in_weight;
    logic        in_ready, out_valid, overflow, busy;
    logic [17:0] out_data;

    logic        n1_start, n1_in_valid, n1_out_ready;
    logic [17:0] n1_bias, n1_in_act, n1_in_weight;
    logic        n1_in_ready, n1_out_valid, n1_overflow, n1_busy;
    logic [17:0] n1_out_data;

    neuron_mac_accumulator #(.N_INPUTS(4), .CNT_W(12)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_weight(in_weight),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .busy(busy)
    );

    neuron_mac_accumulator #(.N_INPUTS(1), .CNT_W(12)) u_dut1 (
        .clk(clk), .rst(rst), .start(n1_start), .bias(n1_bias),
        .in_valid(n1_in_valid), .in_ready(n1_in_ready), .in_act(n1_in_act), .in_weight(n1_in_weight),
        .out_valid(n1_out_valid), .out_ready(n1_out_ready), .out_data(n1_out_data),
        .overflow(n1_overflow), .busy(n1_busy)
    );

    typedef struct packed {
        logic [17:0]       bias;
        logic [3:0][17:0]  act;
        logic [3:0][17:0]  wgt;
        logic [17:0]       exp_data;
        logic              exp_ovf;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [47:0] actual, input logic [47:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic vec_t mk(input logic [17:0] b,
                                input logic [17:0] a0, input logic [17:0] a1,
                                input logic [17:0] a2, input logic [17:0] a3,
                                input logic [17:0] w0, input logic [17:0] w1,
                                input logic [17:0] w2, input logic [17:0] w3,
                                input logic [17:0] d,  input logic o);
        vec_t v;
        v.bias = b;
        v.act[0] = a0; v.act[1] = a1; v.act[2] = a2; v.act[3] = a3;
        v.wgt[0] = w0; v.wgt[1] = w1; v.wgt[2] = w2; v.wgt[3] = w3;
        v.exp_data = d;
        v.exp_ovf  = o;
        return v;
    endfunction

    // Start a neuron, feed its four beats (optionally with gaps), check the result.
    // Entered and left on a falling edge; handshakes immediately if out_ready is high.
    task automatic run_neuron(input vec_t v, input bit gaps, input string tag);
        int b = 0;
        int guard = 0;
        int lat;
        start = 1'b1;
        bias  = v.bias;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_start_ready"}, in_ready, 1);
        while (b < 4 && guard < 200) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid  = 1'b0;
                in_act    = 18'($urandom);
                in_weight = 18'($urandom);
            end else begin
                in_valid  = 1'b1;
                in_act    = v.act[b];
                in_weight = v.wgt[b];
                if (in_ready) b++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        check({tag, "_beats"}, b, 4);
        // Now one falling edge past the last-beat edge; out_valid expected on the third.
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_data"}, out_data, v.exp_data);
        check({tag, "_ovf"}, overflow, v.exp_ovf);
        if (out_ready) begin
            @(negedge clk);
            check({tag, "_valid_one_cycle"}, out_valid, 0);
            check({tag, "_idle"}, busy, 0);
        end
    endtask

    initial begin
        bit          bad;
        int          lat;
        logic [17:0] exp_tiny_neg;
        logic [17:0] exp_round;

`ifdef NEURON_MAC_ROUND_EN
        exp_tiny_neg = 18'h00000;
        exp_round    = 18'h00001;
`else
        exp_tiny_neg = 18'h20001;
        exp_round    = 18'h00000;
`endif

        vecs[0] = mk(18'h00000, 18'h02000, 18'h02000, 18'h02000, 18'h02000,
                     18'h01000, 18'h01000, 18'h01000, 18'h01000, 18'h04000, 1'b0); // 4 x 0.5 = 2.0
        vecs[1] = mk(18'h3E000, 18'h02000, 18'h02000, 18'h02000, 18'h02000,
                     18'h3F000, 18'h3F000, 18'h3F000, 18'h3F000, 18'h26000, 1'b0); // -2 - 1 = -3.0
        vecs[2] = mk(18'h00000, 18'h0E000, 18'h0E000, 18'h0E000, 18'h0E000,
                     18'h0E000, 18'h0E000, 18'h0E000, 18'h0E000, 18'h1FFFF, 1'b1); // +196 saturates
        vecs[3] = mk(18'h00000, 18'h00000, 18'h00000, 18'h00000, 18'h00000,
                     18'h3FFFF, 18'h12345, 18'h20000, 18'h1FFFF, 18'h00000, 1'b0); // zero
        vecs[4] = mk(18'h00000, 18'h0E000, 18'h0E000, 18'h0E000, 18'h0E000,
                     18'h32000, 18'h32000, 18'h32000, 18'h32000, 18'h3FFFF, 1'b1); // -196 saturates
        vecs[5] = mk(18'h00000, 18'h00001, 18'h00001, 18'h00001, 18'h00001,
                     18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, exp_tiny_neg, 1'b0); // -4 LSB of Q8.26
        vecs[6] = mk(18'h00800, 18'h02000, 18'h04000, 18'h3E000, 18'h01000,
                     18'h02000, 18'h02000, 18'h02000, 18'h02000, 18'h05800, 1'b0); // 2.5 + 0.25
        vecs[7] = mk(18'h1FFFF, 18'h00000, 18'h00000, 18'h00000, 18'h00000,
                     18'h00000, 18'h00000, 18'h00000, 18'h00000, 18'h1FFFF, 1'b0); // exactly max
        vecs[8] = mk(18'h1FFFF, 18'h00001, 18'h00000, 18'h00000, 18'h00000,
                     18'h02000, 18'h00000, 18'h00000, 18'h00000, 18'h1FFFF, 1'b1); // max + 1 LSB
        vecs[9] = mk(18'h20000, 18'h00000, 18'h00000, 18'h00000, 18'h00000,
                     18'h00000, 18'h00000, 18'h00000, 18'h00000, 18'h3FFFF, 1'b1); // -16.0

        rst = 1'b1;
        start = 1'b0; bias = '0; in_valid = 1'b0; in_act = '0; in_weight = '0; out_ready = 1'b1;
        n1_start = 1'b0; n1_bias = '0; n1_in_valid = 1'b0; n1_in_act = '0; n1_in_weight = '0;
        n1_out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven neurons, odd entries with random in_valid gaps
        for (int i = 0; i < NV; i++) begin
            run_neuron(vecs[i], (i % 2) == 1, $sformatf("vec%0d", i));
        end

        // Backpressure in HOLD with a stray start pulse
        out_ready = 1'b0;
        run_neuron(vecs[0], 1'b1, "bp");
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            start = (k == 3);
            bias  = 18'h3E000;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 18'h04000 || overflow !== 1'b0 || busy !== 1'b1)
                bad = 1'b1;
        end
        start = 1'b0;
        check("bp_hold_stable", bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", out_valid, 0);
        check("bp_idle", busy, 0);
        repeat (2) @(negedge clk);
        check("bp_start_ignored", in_ready, 0);
        check("bp_still_idle", busy, 0);

        // Asynchronous reset after two of four beats
        start = 1'b1; bias = 18'h00000;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_act = 18'h0E000; in_weight = 18'h0E000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_busy", busy, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_neuron(vecs[0], 1'b0, "post_rst");

        // N_INPUTS=1 instance: ready holds across idle cycles, drops after the single beat
        n1_start = 1'b1; n1_bias = 18'h00000;
        @(negedge clk);
        n1_start = 1'b0;
        check("n1_start_ready", n1_in_ready, 1);
        repeat (2) @(negedge clk);
        check("n1_ready_waits", n1_in_ready, 1);
        n1_in_valid = 1'b1; n1_in_act = 18'h00001; n1_in_weight = 18'h01000;
        @(negedge clk);
        n1_in_valid = 1'b0;
        check("n1_ready_drop", n1_in_ready, 0);
        lat = 1;
        while (!n1_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("n1_latency", lat, 3);
        check("n1_round_data", n1_out_data, exp_round);
        check("n1_round_ovf", n1_overflow, 0);
        @(negedge clk);
        check("n1_idle", n1_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
